// File: rtl/dmem_responder_pkg.sv
// Shared uP16 definitions for the data-memory responder: FSM state encoding and bus limits.
package uP16_pkg;

    localparam int DSIZE_DEF = 16;
    localparam int WAIT_MAX  = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Mem-stage data request bus: the pipeline is the master, dmem_responder is the slave.
interface dmem_responder_if
    import uP16_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) ();

    logic             Enable;
    logic             Write_Enab;
    logic [DSIZE-1:0] Add_In;
    logic [DSIZE-1:0] Data_in;
    logic [DSIZE-1:0] Data_out;
    logic             Ready;
    logic             Busy;
    logic             Err;

    modport master (
        output Enable, Write_Enab, Add_In, Data_in,
        input  Data_out, Ready, Busy, Err
    );

    modport slave (
        input  Enable, Write_Enab, Add_In, Data_in,
        output Data_out, Ready, Busy, Err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: single-port synchronous RAM with registered read; a write echoes its data on the read port.
module dmem_array #(
    parameter int ASIZE = 8,
    parameter int DSIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic             blank,
    input  logic [ASIZE-1:0] addr,
    input  logic [DSIZE-1:0] wdata,
    output logic [DSIZE-1:0] rdata
);

    logic [DSIZE-1:0] mem [2**ASIZE];

    always_ff @(posedge clk) begin
        if (en && we && !blank && !rst)
            mem[addr] <= wdata;
    end

    // rdata only moves on an access, so it holds the last response between requests
    always_ff @(posedge clk) begin
        if (rst)
            rdata <= '0;
        else if (en) begin
            if (blank)
                rdata <= '0;
            else if (we)
                rdata <= wdata;
            else
                rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT cycles, then accesses dmem_array.
// Optional address range check enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_responder #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 8,
    parameter int WAIT  = 2
) (
    input  logic            Clk,
    input  logic            Rst,
    dmem_responder_if.slave bus
);
    import uP16_pkg::dmem_state_t;
    import uP16_pkg::IDLE;
    import uP16_pkg::DONE;
    import uP16_pkg::WAIT_MAX;

    // state | meaning
    // IDLE  | no request pending, accepting
    // WAIT  | request latched, counting wait states (Busy=1)
    // DONE  | access performed, Ready pulse, accepting back-to-back

    if (WAIT > WAIT_MAX || WAIT < 0) begin : g_wait_range
        $error("dmem_responder: WAIT=%0d outside 0..%0d", WAIT, WAIT_MAX);
    end

    dmem_state_t      state;
    logic [3:0]       cnt;
    logic [ASIZE-1:0] lat_addr;
    logic [DSIZE-1:0] lat_data;
    logic             lat_we;
    logic             lat_oob;
    logic             ready_q;
    logic             busy_q;
    logic             err_q;

    logic             req_oob;
    logic             acc_now;
    logic             acc_late;
    logic             acc;
    logic             acc_we;
    logic             acc_oob;
    logic [ASIZE-1:0] acc_addr;
    logic [DSIZE-1:0] acc_data;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign req_oob = |bus.Add_In[DSIZE-1:ASIZE];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.Add_In[DSIZE-1:ASIZE];
    assign req_oob        = 1'b0;
`endif

    // With WAIT=0 the access happens on the accepting edge using the live bus.
    assign acc_now  = (WAIT == 0) && bus.Enable && !Rst
                      && (state == IDLE || state == DONE);
    assign acc_late = (state == uP16_pkg::WAIT) && (cnt == 4'd1) && !Rst;
    assign acc      = acc_now || acc_late;
    assign acc_addr = acc_late ? lat_addr : bus.Add_In[ASIZE-1:0];
    assign acc_data = acc_late ? lat_data : bus.Data_in;
    assign acc_we   = acc_late ? lat_we   : bus.Write_Enab;
    assign acc_oob  = acc_late ? lat_oob  : req_oob;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_we   <= 1'b0;
            lat_oob  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.Enable) begin
                        lat_addr <= bus.Add_In[ASIZE-1:0];
                        lat_data <= bus.Data_in;
                        lat_we   <= bus.Write_Enab;
                        lat_oob  <= req_oob;
                        cnt      <= 4'(WAIT);
                        if (WAIT == 0) begin
                            state   <= DONE;
                            ready_q <= 1'b1;
                            err_q   <= req_oob;
                            busy_q  <= 1'b0;
                        end else begin
                            state  <= uP16_pkg::WAIT;
                            busy_q <= 1'b1;
                        end
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                uP16_pkg::WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        err_q   <= lat_oob;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .ASIZE (ASIZE),
        .DSIZE (DSIZE)
    ) u_array (
        .clk   (Clk),
        .rst   (Rst),
        .en    (acc),
        .we    (acc_we),
        .blank (acc_oob),
        .addr  (acc_addr),
        .wdata (acc_data),
        .rdata (bus.Data_out)
    );

    assign bus.Ready = ready_q;
    assign bus.Busy  = busy_q;
    assign bus.Err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT=2,0,3) against a cycle-level request model.
`timescale 1ns/1ps
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [3];
    logic        en   [3];
    logic        we   [3];
    logic [15:0] addr [3];
    logic [15:0] din  [3];
    logic [15:0] dout [3];
    logic        rdy  [3];
    logic        bsy  [3];
    logic        err  [3];

    int checks = 0;
    int errors = 0;
    bit go = 1'b0;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic        EXP_OOB_ERR  = 1'b1;
    localparam logic [15:0] EXP_ALIAS_RD = 16'hBEEF;
`else
    localparam logic        EXP_OOB_ERR  = 1'b0;
    localparam logic [15:0] EXP_ALIAS_RD = 16'h5555;
`endif

    function automatic int wv(input int i);
        return (i == 0) ? 2 : (i == 1) ? 0 : 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder_if #(.DSIZE(16)) bus ();
        assign bus.Enable     = en[g];
        assign bus.Write_Enab = we[g];
        assign bus.Add_In     = addr[g];
        assign bus.Data_in    = din[g];
        assign dout[g]        = bus.Data_out;
        assign rdy[g]         = bus.Ready;
        assign bsy[g]         = bus.Busy;
        assign err[g]         = bus.Err;
        dmem_responder #(
            .DSIZE (16),
            .ASIZE (8),
            .WAIT  ((g == 0) ? 2 : (g == 1) ? 0 : 3)
        ) u_dut (
            .Clk (clk),
            .Rst (rst[g]),
            .bus (bus)
        );
    end

    function automatic void chk(input string name, input int i,
                                input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h at %0t", name, i, act, exp, $time);
        end
    endfunction

    // Model: a request accepted at edge t completes at edge t+WAIT; busy in between.
    logic [15:0] mmem   [3][256];
    bit          pend   [3];
    int          left   [3];
    logic        p_we   [3];
    logic [15:0] p_addr [3];
    logic [15:0] p_din  [3];
    logic [15:0] m_data [3];
    bit          m_rdy  [3];
    bit          m_busy [3];
    bit          m_err  [3];
    bit          m_oob;
    int          m_k;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                pend[i] = 0; m_rdy[i] = 0; m_busy[i] = 0; m_err[i] = 0; m_data[i] = '0;
            end else begin
                m_rdy[i] = 0;
                m_err[i] = 0;
                if (!pend[i] && en[i]) begin
                    pend[i] = 1; left[i] = wv(i);
                    p_we[i] = we[i]; p_addr[i] = addr[i]; p_din[i] = din[i];
                end
                if (pend[i]) begin
                    if (left[i] == 0) begin
                        pend[i] = 0;
                        m_k = int'(p_addr[i] % 256);
                        m_oob = 0;
`ifdef DMEM_BOUNDS_CHECK_EN
                        m_oob = (p_addr[i] >= 256);
`endif
                        m_rdy[i] = 1;
                        m_err[i] = m_oob;
                        if (m_oob) m_data[i] = '0;
                        else if (p_we[i]) begin
                            mmem[i][m_k] = p_din[i];
                            m_data[i] = p_din[i];
                        end else m_data[i] = mmem[i][m_k];
                    end else left[i] = left[i] - 1;
                end
                m_busy[i] = pend[i];
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            for (int i = 0; i < 3; i++) begin
                chk("model_ready", i, 16'(rdy[i]), 16'(m_rdy[i]));
                chk("model_busy",  i, 16'(bsy[i]), 16'(m_busy[i]));
                chk("model_err",   i, 16'(err[i]), 16'(m_err[i]));
                chk("model_data",  i, dout[i], m_data[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input int i, input logic w, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output int nb, output logic e, output logic [15:0] q);
        int n;
        n = 0;
        nb = 0;
        en[i] = 1'b1; we[i] = w; addr[i] = a; din[i] = d;
        tick();
        en[i] = 1'b0;
        while (rdy[i] !== 1'b1 && n < 40) begin
            if (bsy[i] === 1'b1) nb++;
            tick();
            n++;
        end
        lat = n + 1;
        chk("ready_seen", i, 16'(rdy[i]), 16'h1);
        e = err[i];
        q = dout[i];
        tick();
    endtask

    int          lat;
    int          nb;
    logic        e;
    logic [15:0] q;
    bit          saw;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; din[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        go = 1'b1;
        chk("reset_dout",  0, dout[0], 16'h0);
        chk("reset_ready", 0, 16'(rdy[0]), 16'h0);
        chk("reset_busy",  0, 16'(bsy[0]), 16'h0);
        chk("reset_err",   0, 16'(err[0]), 16'h0);

        do_req(0, 1'b1, 16'h0008, 16'h0000, lat, nb, e, q);
        do_req(1, 1'b1, 16'h0011, 16'h0000, lat, nb, e, q);
        chk("w0_latency", 1, 16'(lat), 16'd1);
        chk("w0_busy_cycles", 1, 16'(nb), 16'd0);
        do_req(2, 1'b1, 16'h0020, 16'h0000, lat, nb, e, q);
        chk("w3_latency", 2, 16'(lat), 16'd4);
        chk("w3_busy_cycles", 2, 16'(nb), 16'd3);

        do_req(0, 1'b1, 16'h0005, 16'hBEEF, lat, nb, e, q);
        chk("w2_wr_latency", 0, 16'(lat), 16'd3);
        chk("w2_wr_busy_cycles", 0, 16'(nb), 16'd2);
        chk("w2_wr_echo", 0, q, 16'hBEEF);
        do_req(0, 1'b0, 16'h0005, 16'h0000, lat, nb, e, q);
        chk("w2_rd_latency", 0, 16'(lat), 16'd3);
        chk("w2_rd_busy_cycles", 0, 16'(nb), 16'd2);
        chk("w2_rd_data", 0, q, 16'hBEEF);

        en[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0010; din[1] = 16'h1234;
        tick();
        chk("b2b_rdy0", 1, 16'(rdy[1]), 16'h1);
        chk("b2b_dat0", 1, dout[1], 16'h1234);
        we[1] = 1'b0; din[1] = 16'hFFFF;
        tick();
        chk("b2b_rdy1", 1, 16'(rdy[1]), 16'h1);
        chk("b2b_dat1", 1, dout[1], 16'h1234);
        addr[1] = 16'h0011;
        tick();
        chk("b2b_rdy2", 1, 16'(rdy[1]), 16'h1);
        chk("b2b_dat2", 1, dout[1], 16'h0000);
        chk("b2b_busy", 1, 16'(bsy[1]), 16'h0);
        en[1] = 1'b0;
        tick();
        chk("b2b_rdy_end", 1, 16'(rdy[1]), 16'h0);

        en[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0020; din[2] = 16'hAAAA;
        tick();
        en[2] = 1'b0;
        saw = 1'b0;
        tick();
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        saw = saw | (rdy[2] === 1'b1);
        repeat (4) begin
            tick();
            saw = saw | (rdy[2] === 1'b1);
        end
        chk("abort_no_ready", 2, 16'(saw), 16'h0);
        do_req(2, 1'b0, 16'h0020, 16'h0000, lat, nb, e, q);
        chk("abort_rd_data", 2, q, 16'h0000);

        en[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0007; din[0] = 16'h1111;
        tick();
        addr[0] = 16'h0008; din[0] = 16'h2222;
        tick();
        we[0] = 1'b0;
        tick();
        chk("ignore_rdy", 0, 16'(rdy[0]), 16'h1);
        chk("ignore_echo", 0, dout[0], 16'h1111);
        en[0] = 1'b0;
        tick();
        do_req(0, 1'b0, 16'h0008, 16'h0000, lat, nb, e, q);
        chk("ignore_rd08", 0, q, 16'h0000);
        do_req(0, 1'b0, 16'h0007, 16'h0000, lat, nb, e, q);
        chk("ignore_rd07", 0, q, 16'h1111);

        do_req(0, 1'b1, 16'h0105, 16'h5555, lat, nb, e, q);
        chk("oob_wr_err", 0, 16'(e), 16'(EXP_OOB_ERR));
        chk("oob_wr_latency", 0, 16'(lat), 16'd3);
        do_req(0, 1'b0, 16'h0005, 16'h0000, lat, nb, e, q);
        chk("oob_rd_data", 0, q, EXP_ALIAS_RD);
        chk("oob_rd_err", 0, 16'(e), 16'h0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
